// File: rtl/perif_bus_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perif_pkg : shared state encoding, window defaults and slot indices  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package perif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_F000;
    localparam logic [31:0] DEFAULT_ERR_DATA  = 32'hBADB_0BAD;

    localparam int SLOT_UART_RX = 5;
    localparam int SLOT_UART_TX = 4;
    localparam int SLOT_TIMER   = 0;

endpackage
`default_nettype wire

// File: rtl/perif_bus_ctrl_slot_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perif_slot_mux : NSLOT:1 selection of slave read data and ready      |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module perif_slot_mux #(
    parameter int NSLOT = 8,
    parameter int IDX_W = $clog2(NSLOT)
) (
    input  logic [IDX_W-1:0]    slot,
    input  logic [32*NSLOT-1:0] perif_rdata,
    input  logic [NSLOT-1:0]    perif_ready,
    output logic [31:0]         sel_rdata,
    output logic                sel_ready
);

    logic [31:0] words [NSLOT];

    generate
        for (genvar i = 0; i < NSLOT; i++) begin : g_unpack
            assign words[i] = perif_rdata[32*i +: 32];
        end
    endgenerate

    always_comb begin
        sel_rdata = words[slot];
        sel_ready = perif_ready[slot];
    end

endmodule
`default_nettype wire

// File: rtl/perif_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perif_bus_ctrl : PicoRV32 peripheral-window decoder with timeout     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module perif_bus_ctrl
    import perif_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          NSLOT      = 8,
    parameter int          SLOT_SHIFT = 4,
    parameter int          TIMEOUT    = 1023,
    parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [31:0]         mem_addr,
    input  logic [3:0]          mem_wstrb,
    input  logic [31:0]         mem_wdata,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic [NSLOT-1:0]    perif_enable,
    output logic                perif_valid,
    output logic [31:0]         perif_addr,
    output logic [3:0]          perif_wstrb,
    output logic [31:0]         perif_wdata,
    input  logic [NSLOT-1:0]    perif_ready,
    input  logic [32*NSLOT-1:0] perif_rdata,
    input  logic                err_clear,
    output logic                bus_error,
    output logic [31:0]         err_addr
);

    localparam int IDX_W = $clog2(NSLOT);
    localparam int WIN_LO = SLOT_SHIFT + IDX_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [IDX_W-1:0] slot;
    logic [CNT_W-1:0] wait_cnt;
    logic             hit;
    logic [IDX_W-1:0] req_slot;
    logic [31:0]      sel_rdata;
    logic             sel_ready;

    assign hit      = (mem_addr[31:WIN_LO] == BASE_ADDR[31:WIN_LO]);
    assign req_slot = mem_addr[WIN_LO-1:SLOT_SHIFT];

    perif_slot_mux #(
        .NSLOT (NSLOT),
        .IDX_W (IDX_W)
    ) u_slot_mux (
        .slot        (slot),
        .perif_rdata (perif_rdata),
        .perif_ready (perif_ready),
        .sel_rdata   (sel_rdata),
        .sel_ready   (sel_ready)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            slot         <= '0;
            wait_cnt     <= '0;
            mem_ready    <= 1'b0;
            mem_rdata    <= '0;
            perif_enable <= '0;
            perif_valid  <= 1'b0;
            perif_addr   <= '0;
            perif_wstrb  <= '0;
            perif_wdata  <= '0;
            bus_error    <= 1'b0;
            err_addr     <= '0;
        end else begin
            mem_ready <= 1'b0;
            // Any error raised below overrides this clear.
            if (err_clear) begin
                bus_error <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (mem_valid && hit) begin
                        if (mem_instr) begin
                            state     <= RESP;
                            mem_ready <= 1'b1;
                            mem_rdata <= ERR_DATA;
                            bus_error <= 1'b1;
                            err_addr  <= mem_addr;
                        end else begin
                            state              <= ACCESS;
                            slot               <= req_slot;
                            wait_cnt           <= '0;
                            perif_valid        <= 1'b1;
                            perif_enable       <= '0;
                            perif_enable[req_slot] <= 1'b1;
                            perif_addr         <= mem_addr;
                            perif_wstrb        <= mem_wstrb;
                            perif_wdata        <= mem_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        state        <= RESP;
                        mem_ready    <= 1'b1;
                        mem_rdata    <= (perif_wstrb == 4'b0000) ? sel_rdata : 32'h0;
                        perif_valid  <= 1'b0;
                        perif_enable <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        state        <= RESP;
                        mem_ready    <= 1'b1;
                        mem_rdata    <= ERR_DATA;
                        bus_error    <= 1'b1;
                        err_addr     <= perif_addr;
                        perif_valid  <= 1'b0;
                        perif_enable <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perif_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_perif_bus_ctrl : directed self-checking bench for perif_bus_ctrl  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_perif_bus_ctrl;
    import perif_pkg::*;

    localparam int TO    = 1023;
    localparam int NS    = 8;
    localparam int BOUND = 2000;

    logic          clk = 1'b0;
    logic          resetn;
    logic          mem_valid, mem_instr;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [NS-1:0] perif_enable;
    logic          perif_valid;
    logic [31:0]   perif_addr, perif_wdata;
    logic [3:0]    perif_wstrb;
    logic [NS-1:0] perif_ready;
    logic [32*NS-1:0] perif_rdata;
    logic          err_clear;
    logic          bus_error;
    logic [31:0]   err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Values captured by run_access
    int            r_lat;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [NS-1:0] r_en1;
    logic          r_v1;
    logic [31:0]   r_addr1, r_wdata1;
    logic [3:0]    r_wstrb1;

    always #5 clk = ~clk;

    perif_bus_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .perif_enable (perif_enable),
        .perif_valid  (perif_valid),
        .perif_addr   (perif_addr),
        .perif_wstrb  (perif_wstrb),
        .perif_wdata  (perif_wdata),
        .perif_ready  (perif_ready),
        .perif_rdata  (perif_rdata),
        .err_clear    (err_clear),
        .bus_error    (bus_error),
        .err_addr     (err_addr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in cycle 0; slot rdy_slot raises ready in cycle rdy_cyc (0 = never).
    task automatic run_access(input logic [31:0] addr, input logic [3:0] wstrb,
                              input logic [31:0] wdata, input logic instr,
                              input int rdy_slot, input int rdy_cyc,
                              input logic [31:0] rdata, input logic [NS-1:0] bg_ready);
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wstrb = wstrb;
        mem_wdata = wdata;
        r_lat     = -1;
        for (int k = 1; k <= BOUND; k++) begin
            step();
            perif_ready = bg_ready;
            if (k == 1) begin
                r_en1    = perif_enable;
                r_v1     = perif_valid;
                r_addr1  = perif_addr;
                r_wstrb1 = perif_wstrb;
                r_wdata1 = perif_wdata;
            end
            if (mem_ready) begin
                r_lat     = k;
                r_rdata   = mem_rdata;
                r_err     = bus_error;
                mem_valid = 1'b0;
                break;
            end
            if (k == rdy_cyc) begin
                perif_ready[rdy_slot]        = 1'b1;
                perif_rdata[rdy_slot*32 +: 32] = rdata;
            end
        end
        if (r_lat < 0) begin
            check_val("mem_ready_bound", 32'(r_lat), 32'(BOUND));
        end
        mem_valid   = 1'b0;
        mem_instr   = 1'b0;
        perif_ready = '0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        mem_valid   = 1'b0;
        mem_instr   = 1'b0;
        mem_addr    = '0;
        mem_wstrb   = '0;
        mem_wdata   = '0;
        perif_ready = '0;
        perif_rdata = '0;
        err_clear   = 1'b0;
        repeat (3) step();

        check_val("rst_mem_ready", 32'(mem_ready), 32'd0);
        check_val("rst_mem_rdata", mem_rdata, 32'h0);
        check_val("rst_enable", 32'(perif_enable), 32'h0);
        check_val("rst_valid", 32'(perif_valid), 32'd0);
        check_val("rst_bus_error", 32'(bus_error), 32'd0);
        check_val("rst_err_addr", err_addr, 32'h0);
        resetn = 1'b1;
        step();

        // uart_rx read, ready in ACCESS cycle 4
        run_access(32'hFFFF_F050, 4'b0000, 32'h0, 1'b0, SLOT_UART_RX, 4, 32'h0000_0051, '0);
        check_val("t1_enable", 32'(r_en1), 32'h0000_0020);
        check_val("t1_valid", 32'(r_v1), 32'd1);
        check_val("t1_addr", r_addr1, 32'hFFFF_F050);
        check_val("t1_latency", 32'(r_lat), 32'd5);
        check_val("t1_rdata", r_rdata, 32'h0000_0051);
        check_val("t1_bus_error", 32'(r_err), 32'd0);
        check_val("t1_idle_valid", 32'(perif_valid), 32'd0);

        // uart_tx write, ready immediately
        run_access(32'hFFFF_F040, 4'b0001, 32'h0000_0041, 1'b0, SLOT_UART_TX, 1, 32'hDEAD_BEEF, '0);
        check_val("t2_enable", 32'(r_en1), 32'h0000_0010);
        check_val("t2_wstrb", 32'(r_wstrb1), 32'h1);
        check_val("t2_wdata", r_wdata1, 32'h0000_0041);
        check_val("t2_latency", 32'(r_lat), 32'd2);
        check_val("t2_rdata", r_rdata, 32'h0);

        // non-hit address is ignored
        begin
            logic seen;
            seen      = 1'b0;
            mem_valid = 1'b1;
            mem_addr  = 32'h0000_1000;
            for (int k = 0; k < 6; k++) begin
                step();
                seen = seen | perif_valid | mem_ready;
            end
            mem_valid = 1'b0;
            check_val("t4_nohit", 32'(seen), 32'd0);
        end

        // instruction fetch from the window
        run_access(32'hFFFF_F000, 4'b0000, 32'h0, 1'b1, SLOT_TIMER, 0, 32'h0, '0);
        check_val("t4_fetch_latency", 32'(r_lat), 32'd1);
        check_val("t4_fetch_rdata", r_rdata, 32'hBADB_0BAD);
        check_val("t4_fetch_err", 32'(r_err), 32'd1);
        check_val("t4_fetch_err_addr", err_addr, 32'hFFFF_F000);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_val("t4_err_cleared", 32'(bus_error), 32'd0);

        // slot 7 never ready
        run_access(32'hFFFF_F070, 4'b0000, 32'h0, 1'b0, 7, 0, 32'h0, '0);
        check_val("t3_latency", 32'(r_lat), 32'(TO + 2));
        check_val("t3_rdata", r_rdata, 32'hBADB_0BAD);
        check_val("t3_bus_error", 32'(r_err), 32'd1);
        check_val("t3_err_addr", err_addr, 32'hFFFF_F070);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_val("t3_err_cleared", 32'(bus_error), 32'd0);
        check_val("t3_err_addr_kept", err_addr, 32'hFFFF_F070);

        // ready on the same cycle the counter reaches TIMEOUT
        run_access(32'hFFFF_F020, 4'b0000, 32'h0, 1'b0, 2, TO + 1, 32'h1234_5678, '0);
        check_val("t5a_latency", 32'(r_lat), 32'(TO + 2));
        check_val("t5a_rdata", r_rdata, 32'h1234_5678);
        check_val("t5a_bus_error", 32'(r_err), 32'd0);

        // spurious ready from slot 3 while slot 2 is selected
        perif_rdata[3*32 +: 32] = 32'hCAFE_0003;
        run_access(32'hFFFF_F020, 4'b0000, 32'h0, 1'b0, 2, 3, 32'h0000_0202, 8'h08);
        check_val("t5c_latency", 32'(r_lat), 32'd4);
        check_val("t5c_rdata", r_rdata, 32'h0000_0202);

        // err_clear held through a timeout: the set wins
        err_clear = 1'b1;
        run_access(32'hFFFF_F060, 4'b0000, 32'h0, 1'b0, 6, 0, 32'h0, '0);
        err_clear = 1'b0;
        check_val("t5b_latency", 32'(r_lat), 32'(TO + 2));
        check_val("t5b_bus_error", 32'(r_err), 32'd1);
        check_val("t5b_err_addr", err_addr, 32'hFFFF_F060);

        // asynchronous reset during ACCESS
        mem_valid = 1'b1;
        mem_addr  = 32'hFFFF_F050;
        mem_wstrb = 4'b0000;
        step();
        step();
        check_val("t6_in_access", 32'(perif_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(perif_valid), 32'd0);
        check_val("t6_rst_enable", 32'(perif_enable), 32'h0);
        check_val("t6_rst_mem_ready", 32'(mem_ready), 32'd0);
        check_val("t6_rst_rdata", mem_rdata, 32'h0);
        check_val("t6_rst_bus_error", 32'(bus_error), 32'd0);
        check_val("t6_rst_err_addr", err_addr, 32'h0);
        check_val("t6_rst_addr", perif_addr, 32'h0);
        mem_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
        run_access(32'hFFFF_F050, 4'b0000, 32'h0, 1'b0, SLOT_UART_RX, 4, 32'h0000_0051, '0);
        check_val("t6_post_latency", 32'(r_lat), 32'd5);
        check_val("t6_post_rdata", r_rdata, 32'h0000_0051);
        check_val("t6_post_bus_error", 32'(r_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
